// File: rtl/hack_pkg.sv
// Shared constants for the Hack keyboard path.
//   - Hack key codes for the non-printing keys (newline .. F12).
//   - PS/2 scan-code set 2 prefix bytes (extended, break).
//   - Receiver state encoding used by ps2_rx.
package hack_pkg;

   localparam logic [15:0] KEY_SPACE     = 16'd32;
   localparam logic [15:0] KEY_NEWLINE   = 16'd128;
   localparam logic [15:0] KEY_BACKSPACE = 16'd129;
   localparam logic [15:0] KEY_LEFT      = 16'd130;
   localparam logic [15:0] KEY_UP        = 16'd131;
   localparam logic [15:0] KEY_RIGHT     = 16'd132;
   localparam logic [15:0] KEY_DOWN      = 16'd133;
   localparam logic [15:0] KEY_HOME      = 16'd134;
   localparam logic [15:0] KEY_END       = 16'd135;
   localparam logic [15:0] KEY_PGUP      = 16'd136;
   localparam logic [15:0] KEY_PGDN      = 16'd137;
   localparam logic [15:0] KEY_INSERT    = 16'd138;
   localparam logic [15:0] KEY_DELETE    = 16'd139;
   localparam logic [15:0] KEY_ESC       = 16'd140;
   localparam logic [15:0] KEY_F1        = 16'd141;
   localparam logic [15:0] KEY_F2        = 16'd142;
   localparam logic [15:0] KEY_F3        = 16'd143;
   localparam logic [15:0] KEY_F4        = 16'd144;
   localparam logic [15:0] KEY_F5        = 16'd145;
   localparam logic [15:0] KEY_F6        = 16'd146;
   localparam logic [15:0] KEY_F7        = 16'd147;
   localparam logic [15:0] KEY_F8        = 16'd148;
   localparam logic [15:0] KEY_F9        = 16'd149;
   localparam logic [15:0] KEY_F10       = 16'd150;
   localparam logic [15:0] KEY_F11       = 16'd151;
   localparam logic [15:0] KEY_F12       = 16'd152;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the PS/2 lines, samples data on each
// synchronized falling edge of ps2_clk and assembles 11-bit frames
// (start, 8 data LSB first, odd parity, stop).
//   clk, reset      system clock, synchronous active-high reset
//   ps2_clk/data    asynchronous PS/2 lines, idle high
//   byte_data       last received byte (valid with byte_valid)
//   byte_valid      one-cycle strobe for a good frame
//   rx_err          one-cycle pulse on start/parity/stop error or timeout
//
// state     | meaning
// ----------+-------------------------------------------------
// RX_IDLE   | waiting for the start bit
// RX_DATA   | shifting in data bits 0..7
// RX_PARITY | checking odd parity over data + parity bit
// RX_STOP   | checking the stop bit, then releasing the byte
module ps2_rx
   import hack_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 32000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       rx_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

   logic [1:0] clk_sync;
   logic [1:0] data_sync;
   logic       clk_prev;
   logic       clk_s;
   logic       bit_in;
   logic       fall;

   rx_state_t     state;
   logic [7:0]    shreg;
   logic [2:0]    bit_cnt;
   logic          par_ok;
   logic [TW-1:0] tmo_cnt;

   assign clk_s  = clk_sync[1];
   assign bit_in = data_sync[1];
   assign fall   = clk_prev & ~clk_s;

   // Flops reset to 1 so an idle-high bus never looks like an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_s;
      end
   end

   // Timeout is a down-counter reloaded on every falling edge; it expires
   // on the TIMEOUT_CYCLES-th edge-free cycle inside a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RX_IDLE;
         shreg      <= 8'h00;
         bit_cnt    <= 3'd0;
         par_ok     <= 1'b0;
         tmo_cnt    <= TMO_LOAD;
         byte_data  <= 8'h00;
         byte_valid <= 1'b0;
         rx_err     <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         rx_err     <= 1'b0;
         if (fall) begin
            tmo_cnt <= TMO_LOAD;
            case (state)
               RX_IDLE: begin
                  if (!bit_in) begin
                     state   <= RX_DATA;
                     bit_cnt <= 3'd0;
                  end else begin
                     rx_err <= 1'b1;
                  end
               end
               RX_DATA: begin
                  shreg   <= {bit_in, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= RX_PARITY;
               end
               RX_PARITY: begin
                  par_ok <= ^{shreg, bit_in};
                  state  <= RX_STOP;
               end
               RX_STOP: begin
                  if (bit_in && par_ok) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shreg;
                  end else begin
                     rx_err <= 1'b1;
                  end
                  state <= RX_IDLE;
               end
               default: state <= RX_IDLE;
            endcase
         end else if (state == RX_IDLE) begin
            tmo_cnt <= TMO_LOAD;
         end else if (tmo_cnt == TW'(1)) begin
            state   <= RX_IDLE;
            rx_err  <= 1'b1;
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
            tmo_cnt <= TMO_LOAD;
         end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end for the Hack memory map. Decodes set-2 make/break
// sequences into the Hack key code of the most recently pressed key that is
// still held; 0 when nothing is held.
//   clk, reset      32 MHz system clock, synchronous active-high reset
//   ps2_clk/data    asynchronous PS/2 lines, idle high
//   key             Hack key code for Memory.kbIn (0 = no key)
//   rx_err          one-cycle pulse on any receive error
module ps2_keyboard
   import hack_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 32000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] key,
   output logic        rx_err
);

   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        ext;
   logic        brk;
   logic [15:0] hack_code;

   ps2_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .byte_data (byte_data),
      .byte_valid(byte_valid),
      .rx_err    (rx_err)
   );

   // Shift is ignored: letters always map to uppercase.
   function automatic logic [15:0] translate(input logic [7:0] code,
                                             input logic       is_ext);
      logic [15:0] t;
      t = 16'd0;
      if (is_ext) begin
         case (code)
            8'h6B:   t = KEY_LEFT;
            8'h75:   t = KEY_UP;
            8'h74:   t = KEY_RIGHT;
            8'h72:   t = KEY_DOWN;
            8'h6C:   t = KEY_HOME;
            8'h69:   t = KEY_END;
            8'h7D:   t = KEY_PGUP;
            8'h7A:   t = KEY_PGDN;
            8'h70:   t = KEY_INSERT;
            8'h71:   t = KEY_DELETE;
            default: t = 16'd0;
         endcase
      end else begin
         case (code)
            8'h1C: t = 16'd65;  // A
            8'h32: t = 16'd66;  // B
            8'h21: t = 16'd67;  // C
            8'h23: t = 16'd68;  // D
            8'h24: t = 16'd69;  // E
            8'h2B: t = 16'd70;  // F
            8'h34: t = 16'd71;  // G
            8'h33: t = 16'd72;  // H
            8'h43: t = 16'd73;  // I
            8'h3B: t = 16'd74;  // J
            8'h42: t = 16'd75;  // K
            8'h4B: t = 16'd76;  // L
            8'h3A: t = 16'd77;  // M
            8'h31: t = 16'd78;  // N
            8'h44: t = 16'd79;  // O
            8'h4D: t = 16'd80;  // P
            8'h15: t = 16'd81;  // Q
            8'h2D: t = 16'd82;  // R
            8'h1B: t = 16'd83;  // S
            8'h2C: t = 16'd84;  // T
            8'h3C: t = 16'd85;  // U
            8'h2A: t = 16'd86;  // V
            8'h1D: t = 16'd87;  // W
            8'h22: t = 16'd88;  // X
            8'h35: t = 16'd89;  // Y
            8'h1A: t = 16'd90;  // Z
            8'h16: t = 16'd49;  // 1
            8'h1E: t = 16'd50;  // 2
            8'h26: t = 16'd51;  // 3
            8'h25: t = 16'd52;  // 4
            8'h2E: t = 16'd53;  // 5
            8'h36: t = 16'd54;  // 6
            8'h3D: t = 16'd55;  // 7
            8'h3E: t = 16'd56;  // 8
            8'h46: t = 16'd57;  // 9
            8'h45: t = 16'd48;  // 0
            8'h29: t = KEY_SPACE;
            8'h5A: t = KEY_NEWLINE;
            8'h66: t = KEY_BACKSPACE;
            8'h76: t = KEY_ESC;
            8'h05: t = KEY_F1;
            8'h06: t = KEY_F2;
            8'h04: t = KEY_F3;
            8'h0C: t = KEY_F4;
            8'h03: t = KEY_F5;
            8'h0B: t = KEY_F6;
            8'h83: t = KEY_F7;
            8'h0A: t = KEY_F8;
            8'h01: t = KEY_F9;
            8'h09: t = KEY_F10;
            8'h78: t = KEY_F11;
            8'h07: t = KEY_F12;
            default: t = 16'd0;
         endcase
      end
      return t;
   endfunction

   assign hack_code = translate(byte_data, ext);

   // A break only releases the key currently shown, so rollover keeps the
   // newer key visible while the older one is let go.
   always_ff @(posedge clk) begin
      if (reset) begin
         key <= 16'd0;
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (rx_err) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (byte_valid) begin
         if (byte_data == PS2_EXT) begin
            ext <= 1'b1;
         end else if (byte_data == PS2_BRK) begin
            brk <= 1'b1;
         end else begin
            if (!brk) begin
               if (hack_code != 16'd0) key <= hack_code;
            end else if (hack_code == key) begin
               key <= 16'd0;
            end
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard. Expected key values are queued as each
// frame is sent; a monitor pops and compares on every key change outside
// reset. The PS/2 bit rate and timeout are scaled down to keep runs short.
module tb_ps2_keyboard;

   localparam int TMO  = 300;
   localparam int HALF = 20;
   localparam int GAP  = 80;

   logic        clk = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] key;
   logic        rx_err;

   int total = 0;
   int bad   = 0;
   int err_cnt = 0;
   int err_base;
   logic [15:0] exp_q[$];

   ps2_keyboard #(
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .key     (key),
      .rx_err  (rx_err)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      logic p;
      p = ~(^b) ^ bad_par;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      send_bit(1'b1);
      ps2_data = 1'b1;
      tick(GAP);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(b[i]);
   endtask

   // Key-change scoreboard and rx_err width monitor.
   logic [15:0] prev_key = 16'd0;
   logic        prev_err = 1'b0;
   logic [15:0] exp_v;
   always @(posedge clk) begin
      #1;
      if (rx_err === 1'b1) err_cnt++;
      if (prev_err) begin
         total++;
         assert (rx_err === 1'b0)
         else begin
            bad++;
            $error("FAIL rx_err_width observed=%0b expected=0", rx_err);
         end
      end
      prev_err = (rx_err === 1'b1);
      if (!reset && key !== prev_key) begin
         total++;
         if (exp_q.size() == 0) begin
            assert (exp_q.size() != 0)
            else begin
               bad++;
               $error("FAIL key_unexpected observed=%0d expected=no_change", key);
            end
         end else begin
            exp_v = exp_q.pop_front();
            assert (key === exp_v)
            else begin
               bad++;
               $error("FAIL key_sb observed=%0d expected=%0d", key, exp_v);
            end
         end
      end
      prev_key = key;
   end

   initial begin
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(5);
      check("reset_key", key, 0);
      check("reset_err", rx_err, 0);
      reset = 1'b0;
      tick(5);

      // Reset mid-frame drops the partial byte.
      send_partial(8'h1C, 3);
      reset = 1'b1;
      tick(2);
      check("midreset_key", key, 0);
      reset = 1'b0;
      ps2_data = 1'b1;
      tick(GAP);
      check("midreset_no_err", err_cnt, 0);
      check("midreset_key_after", key, 0);
      exp_q.push_back(16'd65);
      send_frame(8'h1C, 1'b0);
      check("make_a", key, 65);

      // Make / break.
      exp_q.push_back(16'd0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check("break_a", key, 0);
      check("no_err_makebreak", err_cnt, 0);

      // Rollover.
      exp_q.push_back(16'd65);
      send_frame(8'h1C, 1'b0);
      exp_q.push_back(16'd66);
      send_frame(8'h32, 1'b0);
      check("roll_b", key, 66);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check("roll_a_break_ignored", key, 66);
      exp_q.push_back(16'd0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h32, 1'b0);
      check("roll_b_break", key, 0);

      // Extended and special keys.
      exp_q.push_back(16'd131);
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      check("ext_up", key, 131);
      exp_q.push_back(16'd0);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      check("ext_up_break", key, 0);
      exp_q.push_back(16'd128);
      send_frame(8'h5A, 1'b0);
      check("enter", key, 128);
      exp_q.push_back(16'd141);
      send_frame(8'h05, 1'b0);
      check("f1", key, 141);
      exp_q.push_back(16'd0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h05, 1'b0);
      check("f1_break", key, 0);
      check("no_err_ext", err_cnt, 0);

      // Parity error.
      err_base = err_cnt;
      send_frame(8'h1C, 1'b1);
      check("parity_err", err_cnt, err_base + 1);
      check("parity_key", key, 0);
      exp_q.push_back(16'd65);
      send_frame(8'h1C, 1'b0);
      check("after_parity", key, 65);

      // An error clears the extended prefix: plain 75 is unmapped.
      send_frame(8'hE0, 1'b0);
      send_frame(8'h00, 1'b1);
      send_frame(8'h75, 1'b0);
      check("ext_cleared", key, 65);
      // An error clears the break prefix: 32 becomes a make.
      exp_q.push_back(16'd66);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h00, 1'b1);
      send_frame(8'h32, 1'b0);
      check("brk_cleared", key, 66);
      check("flag_err_count", err_cnt, err_base + 3);
      exp_q.push_back(16'd0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h32, 1'b0);
      check("b_release", key, 0);

      // Start-bit error: falling edge with data high while idle.
      err_base = err_cnt;
      send_bit(1'b1);
      tick(GAP);
      check("start_err", err_cnt, err_base + 1);
      check("start_err_key", key, 0);

      // Timeout mid-frame.
      err_base = err_cnt;
      send_partial(8'h29, 3);
      ps2_data = 1'b1;
      tick(TMO + 100);
      check("timeout_err", err_cnt, err_base + 1);
      exp_q.push_back(16'd32);
      send_frame(8'h29, 1'b0);
      check("after_timeout", key, 32);
      check("timeout_single", err_cnt, err_base + 1);

      // Reset while a key is held clears it.
      send_partial(8'h1C, 2);
      reset = 1'b1;
      tick(2);
      check("reset_held_key", key, 0);
      reset = 1'b0;
      ps2_data = 1'b1;
      tick(GAP);
      check("reset_held_after", key, 0);

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
